alu_seg_display: RTL and testbench

//  Board-side output driver for the ALU demo: the output-direction counterpart of the

---
 rtl/alu_seg_display_pkg.sv | 33 +++
 rtl/alu_seg_display_if.sv | 21 ++
 rtl/alu_seg_display_seg7_decoder.sv | 24 ++
 rtl/alu_seg_display.sv | 124 ++++++++++++
 tb/tb_alu_seg_display.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_seg_display_pkg.sv
// Shared glyph constants, digit-code types and sizes for the ALU 7-segment display driver.
// Glyphs are active-low with bit0=a .. bit6=g, bit7=dp (dp off in all constants).
package alu_disp_pkg;

    localparam int DIGITS = 4;
    localparam int IDX_W  = $clog2(DIGITS);

    localparam logic [7:0] GLY_BLANK = 8'hFF;
    localparam logic [7:0] GLY_MINUS = 8'hBF;
    localparam logic [7:0] GLY_O     = 8'hA3;
    localparam logic [7:0] GLY_C     = 8'hA7;
    localparam logic [7:0] GLY_Z     = 8'hA4;

    // Index n selects the glyph for hex digit n.
    localparam logic [15:0][7:0] HEX_GLYPH = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic [3:0] {
        SP_BLANK = 4'd0,
        SP_MINUS = 4'd1,
        SP_O     = 4'd2,
        SP_C     = 4'd3,
        SP_Z     = 4'd4
    } special_e;

    typedef struct packed {
        logic       special;
        logic [3:0] code;
    } digit_code_t;

endpackage

// File: rtl/alu_seg_display_if.sv
// Board-facing bundle: ALU state into the display driver, segment/anode drive out.
interface alu_disp_if;
    logic [2:0]        instr;
    logic              en;
    logic signed [3:0] result;
    logic              zero;
    logic              carry;
    logic              overflow;
    logic [7:0]        seg_n;
    logic [3:0]        an_n;

    modport master (
        output instr, en, result, zero, carry, overflow,
        input  seg_n, an_n
    );

    modport slave (
        input  instr, en, result, zero, carry, overflow,
        output seg_n, an_n
    );
endinterface

// File: rtl/alu_seg_display_seg7_decoder.sv
// Combinational digit-code to 7-segment decoder; special codes select non-hex symbols.
module seg7_decoder
    import alu_disp_pkg::*;
(
    input  digit_code_t i_digit,
    output logic [6:0]  o_seg_n
);

    always_comb begin
        o_seg_n = GLY_BLANK[6:0];
        if (i_digit.special) begin
            case (i_digit.code)
                SP_MINUS: o_seg_n = GLY_MINUS[6:0];
                SP_O:     o_seg_n = GLY_O[6:0];
                SP_C:     o_seg_n = GLY_C[6:0];
                SP_Z:     o_seg_n = GLY_Z[6:0];
                default:  o_seg_n = GLY_BLANK[6:0];
            endcase
        end else begin
            o_seg_n = HEX_GLYPH[i_digit.code][6:0];
        end
    end

endmodule

// File: rtl/alu_seg_display.sv
// 4-digit multiplexed display of opcode, signed result and status flag; the result
// freezes and the opcode digit blinks while the ALU is disabled.
module alu_seg_display
    import alu_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_disp_if.slave  bus
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int BLK_W = $clog2(BLINK_DIV);

    logic              r_en_meta;
    logic              r_en_s;
    logic [2:0]        r_instr;
    logic signed [3:0] r_res;
    logic              r_z;
    logic              r_c;
    logic              r_v;
    logic [PRE_W-1:0]  r_pre;
    logic [IDX_W-1:0]  r_idx;
    logic [BLK_W-1:0]  r_blk_cnt;
    logic              r_phase;
    logic [3:0]        r_an_n;
    logic [7:0]        r_seg_n;

    logic [3:0]        w_res_mag;
    digit_code_t       w_code;
    logic [6:0]        w_seg7;
    logic [7:0]        w_glyph;

    // A 4-bit negate is enough: -8 wraps to 4'b1000, which reads as 8.
    assign w_res_mag = r_res[3] ? (4'd0 - r_res) : r_res;

    always_comb begin
        w_code = '{special: 1'b1, code: SP_BLANK};
        case (r_idx)
            2'd3: w_code = '{special: 1'b0, code: {1'b0, r_instr}};
            2'd2: w_code = '{special: 1'b1, code: (r_res[3] ? SP_MINUS : SP_BLANK)};
            2'd1: w_code = '{special: 1'b0, code: w_res_mag};
            default: begin
                if (r_v)      w_code = '{special: 1'b1, code: SP_O};
                else if (r_c) w_code = '{special: 1'b1, code: SP_C};
                else if (r_z) w_code = '{special: 1'b1, code: SP_Z};
                else          w_code = '{special: 1'b1, code: SP_BLANK};
            end
        endcase
    end

    seg7_decoder u_dec (
        .i_digit (w_code),
        .o_seg_n (w_seg7)
    );

    always_comb begin
        w_glyph = {1'b1, w_seg7};
        if (r_idx == IDX_W'(DIGITS - 1)) begin
            w_glyph[7] = ~r_en_s;
            if (r_phase) w_glyph = GLY_BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_meta <= 1'b0;
            r_en_s    <= 1'b0;
            r_instr   <= '0;
            r_res     <= '0;
            r_z       <= 1'b0;
            r_c       <= 1'b0;
            r_v       <= 1'b0;
            r_pre     <= '0;
            r_idx     <= '0;
            r_blk_cnt <= '0;
            r_phase   <= 1'b0;
            r_an_n    <= 4'hF;
            r_seg_n   <= GLY_BLANK;
        end else begin
            r_en_meta <= bus.en;
            r_en_s    <= r_en_meta;
            r_instr   <= bus.instr;
            if (r_en_s) begin
                r_res <= bus.result;
                r_z   <= bus.zero;
                r_c   <= bus.carry;
                r_v   <= bus.overflow;
            end

            if (r_pre == PRE_W'(SCAN_DIV - 1)) begin
                r_pre <= '0;
                r_idx <= r_idx + IDX_W'(1);
            end else begin
                r_pre <= r_pre + PRE_W'(1);
            end

            if (r_en_s) begin
                r_blk_cnt <= '0;
                r_phase   <= 1'b0;
            end else if (r_blk_cnt == BLK_W'(BLINK_DIV - 1)) begin
                r_blk_cnt <= '0;
                r_phase   <= ~r_phase;
            end else begin
                r_blk_cnt <= r_blk_cnt + BLK_W'(1);
            end

            // First cycle of each slot is dark so the previous digit cannot ghost.
            if (r_pre == '0) begin
                r_an_n  <= 4'hF;
                r_seg_n <= GLY_BLANK;
            end else begin
                r_an_n  <= ~(4'b0001 << r_idx);
                r_seg_n <= w_glyph;
            end
        end
    end

    assign bus.seg_n = r_seg_n;
    assign bus.an_n  = r_an_n;

endmodule

// File: tb/tb_alu_seg_display.sv
// Bench for alu_seg_display: directed scenarios plus random traffic, all checked
// against a cycle-level arithmetic model of the display.
module tb_alu_seg_display;

    localparam int S = 4;
    localparam int B = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_disp_if bus ();

    alu_seg_display #(.SCAN_DIV(S), .BLINK_DIV(B)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [3:0] AN_SEQ [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};

    // Model state: what the display should be showing, derived from elapsed cycles.
    bit         m_meta, m_ens;
    logic [2:0] m_instr;
    logic [3:0] m_res;
    bit         m_z, m_c, m_v;
    int         n_cyc, off_cyc;
    logic [3:0] m_an;
    logic [7:0] m_seg;

    function automatic logic [7:0] model_glyph(int d);
        int val, mag;
        logic [7:0] g;
        case (d)
            3: begin
                if ((off_cyc / B) % 2 == 1) return 8'hFF;
                g = HEX[m_instr];
                g[7] = ~m_ens;
                return g;
            end
            2: return m_res[3] ? 8'hBF : 8'hFF;
            1: begin
                val = m_res[3] ? int'(m_res) - 16 : int'(m_res);
                mag = (val < 0) ? -val : val;
                return HEX[mag];
            end
            default: begin
                if (m_v) return 8'hA3;
                if (m_c) return 8'hA7;
                if (m_z) return 8'hA4;
                return 8'hFF;
            end
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_meta = 0; m_ens = 0; m_instr = '0; m_res = '0;
            m_z = 0; m_c = 0; m_v = 0; n_cyc = 0; off_cyc = 0;
            m_an = 4'hF; m_seg = 8'hFF;
        end else begin
            if (n_cyc % S == 0) begin
                m_an = 4'hF;
                m_seg = 8'hFF;
            end else begin
                m_an = ~(4'b0001 << ((n_cyc / S) % 4));
                m_seg = model_glyph((n_cyc / S) % 4);
            end
            n_cyc++;
            off_cyc = m_ens ? 0 : off_cyc + 1;
            m_instr = bus.instr;
            if (m_ens) begin
                m_res = bus.result; m_z = bus.zero; m_c = bus.carry; m_v = bus.overflow;
            end
            m_ens = m_meta;
            m_meta = bus.en;
        end
    end

    task automatic cmp4(string tag, logic [3:0] obs, logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp8(string tag, logic [7:0] obs, logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(string tag);
        cmp4({tag, ".an_n"}, bus.an_n, m_an);
        cmp8({tag, ".seg_n"}, bus.seg_n, m_seg);
    endtask

    task automatic step(int k, string tag);
        repeat (k) begin
            @(negedge clk);
            check_model(tag);
        end
    endtask

    task automatic check_digit(int d, logic [7:0] exp, string tag);
        logic [3:0] want;
        bit found;
        want = ~(4'b0001 << d);
        found = 0;
        for (int t = 0; t < 24 && !found; t++) begin
            @(negedge clk);
            check_model(tag);
            if (bus.an_n === want) found = 1;
        end
        n_cmp++;
        assert (found) else begin
            n_fail++;
            $error("FAIL %s.slot observed=not_seen expected=an_n_%h", tag, want);
        end
        if (found) cmp8({tag, ".glyph"}, bus.seg_n, exp);
    endtask

    task automatic wait_phase1(string tag);
        bit hit;
        hit = 0;
        for (int t = 0; t < 40 && !hit; t++) begin
            @(negedge clk);
            check_model(tag);
            if ((off_cyc / B) % 2 == 1) hit = 1;
        end
        n_cmp++;
        assert (hit) else begin
            n_fail++;
            $error("FAIL %s.phase observed=0 expected=1", tag);
        end
    endtask

    initial begin
        bus.instr = '0; bus.en = 0; bus.result = '0;
        bus.zero = 0; bus.carry = 0; bus.overflow = 0;

        repeat (3) @(negedge clk);
        cmp4("reset.an_n", bus.an_n, 4'hF);
        cmp8("reset.seg_n", bus.seg_n, 8'hFF);

        rst_n = 1'b1;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            cmp4("scan.seq", bus.an_n, AN_SEQ[i % 16]);
            check_model("scan");
        end

        bus.en = 1; bus.instr = 3'd3; bus.result = 4'b1101;
        step(6, "t2");
        check_digit(3, 8'h30, "t2.d3");
        check_digit(2, 8'hBF, "t2.d2");
        check_digit(1, 8'hB0, "t2.d1");
        check_digit(0, 8'hFF, "t2.d0");

        bus.en = 0;
        step(4, "t4");
        bus.result = 4'b0101;
        step(2, "t4");
        check_digit(1, 8'hB0, "t4.d1");
        check_digit(2, 8'hBF, "t4.d2");
        step(40, "t4.blink");

        bus.en = 1; bus.result = 4'b1000; bus.overflow = 1; bus.zero = 1;
        step(6, "t5");
        check_digit(2, 8'hBF, "t5.d2");
        check_digit(1, 8'h80, "t5.d1");
        check_digit(0, 8'hA3, "t5.d0");

        bus.en = 0;
        wait_phase1("t6");
        bus.en = 1; bus.result = 4'b1110;
        step(5, "t6");
        check_digit(3, 8'h30, "t6.d3");
        check_digit(1, 8'hA4, "t6.d1");

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp4("midrst.an_n", bus.an_n, 4'hF);
        cmp8("midrst.seg_n", bus.seg_n, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cmp4("rescan.seq", bus.an_n, AN_SEQ[i]);
            check_model("rescan");
        end

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            check_model("rand");
            bus.instr    = 3'($urandom);
            bus.result   = 4'($urandom);
            bus.zero     = 1'($urandom);
            bus.carry    = 1'($urandom);
            bus.overflow = 1'($urandom);
            if ($urandom_range(0, 15) == 0) bus.en = ~bus.en;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
